// File: rtl/xgriscv_lsu_pkg.sv
// xgriscv_lsu_pkg: shared widths, funct3 codes, FSM encoding and load-extension helper
// for the load/store unit.
//   lsu_extend(funct3, d): sign/zero-extends right-aligned byte/half data, passes words through.
package xgriscv_lsu_pkg;
    localparam int XLEN      = 32;
    localparam int ADDR_SIZE = 32;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    function automatic logic [XLEN-1:0] lsu_extend(input logic [2:0] funct3, input logic [XLEN-1:0] d);
        return funct3[1] ? d :
               funct3[0] ? {{16{d[15] & ~funct3[2]}}, d[15:0]} :
                           {{24{d[7] & ~funct3[2]}}, d[7:0]};
    endfunction
endpackage

// File: rtl/xgriscv_lsu_align.sv
// xgriscv_lsu_align: combinational lane logic for one memory access.
//   we_i/funct3_i/off_i : access kind and byte offset within the word
//   wdata_i             : right-aligned store data
//   rd_i                : memory read word
//   amp_o/wd_o          : byte-lane mask and lane-replicated write data
//   misaligned_o        : half at odd offset or word at non-zero offset
//   illegal_o           : funct3 not valid for this direction
//   rdata_o             : selected lanes of rd_i, extended per funct3
module xgriscv_lsu_align
    import xgriscv_lsu_pkg::*;
(
    input  logic            we_i,
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      off_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] rd_i,
    output logic [3:0]      amp_o,
    output logic [XLEN-1:0] wd_o,
    output logic            misaligned_o,
    output logic            illegal_o,
    output logic [XLEN-1:0] rdata_o
);
    logic [1:0] size;
    assign size = funct3_i[1:0];
    // Unsigned variants exist only for loads of bytes/halves.
    assign illegal_o    = (size == 2'b11) || (funct3_i[2] && (we_i || size == 2'b10));
    assign misaligned_o = (size == 2'b01 && off_i[0]) || (size == 2'b10 && off_i != 2'b00);
    assign amp_o = size == 2'b00 ? 4'b0001 << off_i :
                   size == 2'b01 ? (off_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wd_o  = size == 2'b00 ? {4{wdata_i[7:0]}} :
                   size == 2'b01 ? {2{wdata_i[15:0]}} : wdata_i;
    assign rdata_o = lsu_extend(funct3_i, rd_i >> {off_i, 3'b000});
endmodule

// File: rtl/xgriscv_lsu.sv
// xgriscv_lsu: single-outstanding load/store unit driving a combinational-read data memory.
//   clk_i, rstn_i (async, active low)
//   req_*  : request channel (valid/ready), we, funct3, byte address, right-aligned wdata
//   resp_* : response channel (valid/ready), extended load data, error flag
//   dm_*   : memory port (we, byte-lane mask, byte address, write data, read data)
// Build option: XGRISCV_LSU_MISALIGN_SPLIT_EN executes misaligned h/w accesses as
// ascending byte accesses instead of reporting an error.
module xgriscv_lsu
    import xgriscv_lsu_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [2:0]           req_funct3_i,
    input  logic [ADDR_SIZE-1:0] req_addr_i,
    input  logic [XLEN-1:0]      req_wdata_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic [XLEN-1:0]      resp_rdata_o,
    output logic                 resp_err_o,
    output logic                 dm_we_o,
    output logic [3:0]           dm_amp_o,
    output logic [ADDR_SIZE-1:0] dm_a_o,
    output logic [XLEN-1:0]      dm_wd_o,
    input  logic [XLEN-1:0]      dm_rd_i
);
`ifdef XGRISCV_LSU_MISALIGN_SPLIT_EN
    localparam logic SPLIT_EN = 1'b1;
`else
    localparam logic SPLIT_EN = 1'b0;
`endif
    logic [1:0]           state_q, state_d;
    logic                 we_q, we_d;
    logic [2:0]           f3_q, f3_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [XLEN-1:0]      wdata_q, wdata_d;
    logic [XLEN-1:0]      rdata_q, rdata_d;
    logic [1:0]           cnt_q, cnt_d;
    logic                 split_q, split_d;
    logic                 err_q, err_d;
    logic                 idle, acc, resp, last;
    logic [ADDR_SIZE-1:0] dm_addr;
    logic [XLEN-1:0]      asm_data;
    logic                 al_we, al_mis, al_ill;
    logic [2:0]           al_f3;
    logic [1:0]           al_off;
    logic [3:0]           al_amp;
    logic [XLEN-1:0]      al_wdata, al_wd, al_rdata;
    assign idle    = state_q == S_IDLE;
    assign acc     = state_q == S_ACC;
    assign resp    = state_q == S_RESP;
    assign dm_addr = addr_q + ADDR_SIZE'(cnt_q);
    // While idle the aligner classifies the incoming request; afterwards it serves the
    // registered access, forced to an unsigned byte on each step of a split sequence.
    assign al_we    = idle ? req_we_i : we_q;
    assign al_f3    = idle ? req_funct3_i : split_q ? F3_BU : f3_q;
    assign al_off   = idle ? req_addr_i[1:0] : dm_addr[1:0];
    assign al_wdata = wdata_q >> {cnt_q, 3'b000};
    // Split sequence ends after 2 bytes for halves, 4 for words.
    assign last     = cnt_q == (f3_q[1] ? 2'd3 : 2'd1);
    assign asm_data = rdata_q | (XLEN'(al_rdata[7:0]) << {cnt_q, 3'b000});
    xgriscv_lsu_align u_align (
        .we_i         (al_we),
        .funct3_i     (al_f3),
        .off_i        (al_off),
        .wdata_i      (al_wdata),
        .rd_i         (dm_rd_i),
        .amp_o        (al_amp),
        .wd_o         (al_wd),
        .misaligned_o (al_mis),
        .illegal_o    (al_ill),
        .rdata_o      (al_rdata)
    );
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        split_d = split_q;
        err_d   = err_q;
        if (idle && req_valid_i) begin
            we_d    = req_we_i;
            f3_d    = req_funct3_i;
            addr_d  = req_addr_i;
            wdata_d = req_wdata_i;
            rdata_d = '0;
            cnt_d   = 2'd0;
            err_d   = al_ill || (al_mis && !SPLIT_EN);
            split_d = al_mis && SPLIT_EN && !al_ill;
            state_d = err_d ? S_RESP : S_ACC;
        end
        if (acc) begin
            rdata_d = we_q ? '0 : !split_q ? al_rdata : last ? lsu_extend(f3_q, asm_data) : asm_data;
            cnt_d   = cnt_q + 2'd1;
            state_d = (!split_q || last) ? S_RESP : S_ACC;
        end
        if (resp && resp_ready_i)
            state_d = S_IDLE;
    end
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= 2'd0;
            split_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            split_q <= split_d;
            err_q   <= err_d;
        end
    end
    assign req_ready_o  = idle;
    assign resp_valid_o = resp;
    assign resp_rdata_o = resp ? rdata_q : '0;
    assign resp_err_o   = resp & err_q;
    assign dm_we_o      = acc & we_q;
    assign dm_amp_o     = acc ? al_amp : 4'b0000;
    assign dm_a_o       = acc ? dm_addr : '0;
    assign dm_wd_o      = acc ? al_wd : '0;
endmodule

// File: tb/tb_xgriscv_lsu.sv
// tb_xgriscv_lsu: randomized self-checking bench for xgriscv_lsu with a byte-array memory
// and a byte-level reference model of load/store semantics.
module tb_xgriscv_lsu;
`ifdef XGRISCV_LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, dm_we;
    logic [31:0] resp_rdata, dm_a, dm_wd, dm_rd;
    logic [3:0]  dm_amp;
    logic [7:0]  mem [1024] = '{default: 8'h00};
    logic [7:0]  ref_mem [1024];
    int          n_cmp = 0, n_fail = 0;

    always #5 clk = ~clk;

    xgriscv_lsu dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_funct3_i (req_funct3),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err),
        .dm_we_o      (dm_we),
        .dm_amp_o     (dm_amp),
        .dm_a_o       (dm_a),
        .dm_wd_o      (dm_wd),
        .dm_rd_i      (dm_rd)
    );

    always @(posedge clk)
        if (dm_we)
            for (int l = 0; l < 4; l++)
                if (dm_amp[l]) mem[{dm_a[9:2], 2'(l)}] <= dm_wd[8*l +: 8];

    assign dm_rd = {mem[{dm_a[9:2], 2'd3}], mem[{dm_a[9:2], 2'd2}],
                    mem[{dm_a[9:2], 2'd1}], mem[{dm_a[9:2], 2'd0}]};

    // Reference: byte-granular memory, little-endian, n = 1/2/4 bytes.
    task automatic ref_model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, output logic [31:0] rd, output logic e,
                             output int nacc, output int lat);
        int n;
        logic legal, mis;
        logic [31:0] v;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        n = 1 << f3[1:0];
        mis = (int'(a[1:0]) % n) != 0;
        rd = '0;
        e = !legal || (mis && !SPLIT);
        nacc = e ? 0 : (mis ? n : 1);
        lat = nacc + 1;
        if (!e && we)
            for (int i = 0; i < n; i++) ref_mem[10'(a + 32'(i))] = wd[8*i +: 8];
        if (!e && !we) begin
            v = '0;
            for (int i = 0; i < n; i++) v = v | (32'(ref_mem[10'(a + 32'(i))]) << (8*i));
            if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
            rd = v;
        end
    endtask

    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic e,
                        output int nacc, output int nwe, output int lat,
                        output logic [31:0] fa, output logic [3:0] famp, output logic [31:0] fwd);
        int k;
        nacc = 0; nwe = 0; lat = 0; rd = '0; e = 1'b0; fa = '0; famp = '0; fwd = '0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        k = 0;
        while (!req_ready && k < 20) begin @(negedge clk); k++; end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        req_funct3 = 3'($urandom); req_we = 1'($urandom);
        lat = 1;
        while (!resp_valid && lat < 20) begin
            if (dm_amp != 4'b0000) begin
                if (nacc == 0) begin fa = dm_a; famp = dm_amp; fwd = dm_wd; end
                nacc++;
            end
            if (dm_we) nwe++;
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (!resp_valid) begin
            n_fail++;
            $display("FAIL resp_timeout: resp_valid=%b after %0d cycles, required 1", resp_valid, lat);
        end
        rd = resp_rdata; e = resp_err;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (6) begin
            @(negedge clk);
            req_valid = 1'($urandom); req_we = 1'($urandom); req_funct3 = 3'($urandom);
            req_addr = $urandom; req_wdata = $urandom; resp_ready = 1'($urandom);
            #1;
            n_cmp++;
            if ({req_ready, resp_valid, resp_err, dm_we, dm_amp} !== 8'b1000_0000) begin
                n_fail++;
                $display("FAIL reset_ctrl: rdy/rv/err/we/amp=%b required 10000000",
                         {req_ready, resp_valid, resp_err, dm_we, dm_amp});
            end
            n_cmp++;
            if ({resp_rdata, dm_a, dm_wd} !== 96'd0) begin
                n_fail++;
                $display("FAIL reset_data: rdata=%h a=%h wd=%h required 0", resp_rdata, dm_a, dm_wd);
            end
        end
        @(negedge clk);
        req_valid = 1'b0; resp_ready = 1'b0;
        rstn = 1'b1;
    endtask

    task automatic test_store_byte();
        logic [31:0] rd, er, fa, fwd;
        logic e, ee;
        logic [3:0] famp;
        int nacc, nwe, lat, ea, el;
        ref_model(1'b1, 3'b000, 32'h102, 32'h0000_00A5, er, ee, ea, el);
        xact(1'b1, 3'b000, 32'h102, 32'h0000_00A5, rd, e, nacc, nwe, lat, fa, famp, fwd);
        n_cmp++;
        if ({famp, fa, fwd} !== {4'b0100, 32'h102, 32'hA5A5_A5A5}) begin
            n_fail++;
            $display("FAIL sb_lanes: amp=%b a=%h wd=%h required 0100/102/a5a5a5a5", famp, fa, fwd);
        end
        n_cmp++;
        if (nwe !== 1 || nacc !== 1 || lat !== 2) begin
            n_fail++;
            $display("FAIL sb_timing: we_pulses=%0d acc=%0d lat=%0d required 1/1/2", nwe, nacc, lat);
        end
        n_cmp++;
        if ({rd, e} !== 33'd0) begin
            n_fail++;
            $display("FAIL sb_resp: rdata=%h err=%b required 0/0", rd, e);
        end
        ref_model(1'b0, 3'b100, 32'h102, 32'h0, er, ee, ea, el);
        xact(1'b0, 3'b100, 32'h102, 32'h0, rd, e, nacc, nwe, lat, fa, famp, fwd);
        n_cmp++;
        if (rd !== 32'h0000_00A5) begin
            n_fail++;
            $display("FAIL sb_readback: rdata=%h required 000000a5", rd);
        end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b001, 3'b010, 3'b101};
        logic [31:0] adrs [5] = '{32'h40, 32'h40, 32'h42, 32'h40, 32'h42};
        logic [31:0] exps [5] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_8000, 32'h8000_F0FF, 32'h0000_8000};
        logic [31:0] rd, er, fa, fwd;
        logic e, ee;
        logic [3:0] famp;
        int nacc, nwe, lat, ea, el;
        ref_model(1'b1, 3'b010, 32'h40, 32'h8000_F0FF, er, ee, ea, el);
        xact(1'b1, 3'b010, 32'h40, 32'h8000_F0FF, rd, e, nacc, nwe, lat, fa, famp, fwd);
        n_cmp++;
        if (famp !== 4'b1111 || fwd !== 32'h8000_F0FF || e !== 1'b0) begin
            n_fail++;
            $display("FAIL sw_setup: amp=%b wd=%h err=%b required 1111/8000f0ff/0", famp, fwd, e);
        end
        for (int i = 0; i < 5; i++) begin
            ref_model(1'b0, f3s[i], adrs[i], 32'h0, er, ee, ea, el);
            xact(1'b0, f3s[i], adrs[i], 32'h0, rd, e, nacc, nwe, lat, fa, famp, fwd);
            n_cmp++;
            if (rd !== exps[i] || e !== 1'b0 || nwe !== 0) begin
                n_fail++;
                $display("FAIL load_ext[%0d]: rdata=%h err=%b we_pulses=%0d required %h/0/0",
                         i, rd, e, nwe, exps[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] e1, e2, held;
        logic ee;
        int ea, el, k;
        ref_model(1'b0, 3'b010, 32'h40, 32'h0, e1, ee, ea, el);
        ref_model(1'b0, 3'b100, 32'h40, 32'h0, e2, ee, ea, el);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40;
        @(posedge clk);
        @(negedge clk);
        req_funct3 = 3'b100;
        k = 0;
        while (!resp_valid && k < 10) begin @(negedge clk); k++; end
        held = resp_rdata;
        n_cmp++;
        if (held !== e1) begin
            n_fail++;
            $display("FAIL bp_first: rdata=%h required %h", held, e1);
        end
        repeat (5) begin
            @(negedge clk);
            n_cmp++;
            if ({resp_valid, req_ready, resp_rdata} !== {1'b1, 1'b0, e1}) begin
                n_fail++;
                $display("FAIL bp_hold: valid=%b ready=%b rdata=%h required 1/0/%h",
                         resp_valid, req_ready, resp_rdata, e1);
            end
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        n_cmp++;
        if ({req_ready, resp_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL bp_idle: ready=%b valid=%b required 1/0", req_ready, resp_valid);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (!resp_valid && k < 10) begin @(negedge clk); k++; end
        n_cmp++;
        if (resp_valid !== 1'b1 || resp_rdata !== e2) begin
            n_fail++;
            $display("FAIL bp_second: valid=%b rdata=%h required 1/%h", resp_valid, resp_rdata, e2);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_misaligned();
        logic [31:0] rd, er, fa, fwd;
        logic e, ee;
        logic [3:0] famp;
        int nacc, nwe, lat, ea, el;
        logic [31:0] adrs [2] = '{32'h40, 32'h44};
        ref_model(1'b1, 3'b010, 32'h41, 32'h1122_3344, er, ee, ea, el);
        xact(1'b1, 3'b010, 32'h41, 32'h1122_3344, rd, e, nacc, nwe, lat, fa, famp, fwd);
        n_cmp++;
        if (e !== SPLIT ? 1'b0 : 1'b1) begin end
        if (e !== !SPLIT || nwe !== (SPLIT ? 4 : 0) || rd !== 32'd0) begin
            n_fail++;
            $display("FAIL sw_mis: err=%b we_pulses=%0d rdata=%h required %b/%0d/0",
                     e, nwe, rd, !SPLIT, SPLIT ? 4 : 0);
        end
        n_cmp++;
        if (SPLIT && (fa !== 32'h41 || famp !== 4'b0010 || fwd !== 32'h4444_4444)) begin
            n_fail++;
            $display("FAIL sw_mis_first: a=%h amp=%b wd=%h required 41/0010/44444444", fa, famp, fwd);
        end
        for (int i = 0; i < 2; i++) begin
            ref_model(1'b0, 3'b010, adrs[i], 32'h0, er, ee, ea, el);
            xact(1'b0, 3'b010, adrs[i], 32'h0, rd, e, nacc, nwe, lat, fa, famp, fwd);
            n_cmp++;
            if (rd !== er || e !== 1'b0) begin
                n_fail++;
                $display("FAIL mis_readback[%0d]: rdata=%h err=%b required %h/0", i, rd, e, er);
            end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] rd, fa, fwd;
        logic e;
        logic [3:0] famp;
        int nacc, nwe, lat;
        logic        wes [2] = '{1'b0, 1'b1};
        logic [2:0]  f3s [2] = '{3'b011, 3'b100};
        for (int i = 0; i < 2; i++) begin
            xact(wes[i], f3s[i], 32'h60, 32'hDEAD_BEEF, rd, e, nacc, nwe, lat, fa, famp, fwd);
            n_cmp++;
            if (e !== 1'b1 || rd !== 32'd0 || nacc !== 0 || nwe !== 0 || lat !== 1) begin
                n_fail++;
                $display("FAIL illegal[%0d]: err=%b rdata=%h acc=%0d we_pulses=%0d lat=%0d required 1/0/0/0/1",
                         i, e, rd, nacc, nwe, lat);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, er, fa, fwd, a, wd;
        logic e, ee, we;
        logic [2:0] f3;
        logic [3:0] famp;
        int nacc, nwe, lat, ea, el;
        for (int k = 0; k < 64; k++) begin
            wd = $urandom;
            ref_model(1'b1, 3'b010, 32'h100 + 32'(4*k), wd, er, ee, ea, el);
            xact(1'b1, 3'b010, 32'h100 + 32'(4*k), wd, rd, e, nacc, nwe, lat, fa, famp, fwd);
        end
        for (int t = 0; t < 300; t++) begin
            we = 1'($urandom); f3 = 3'($urandom);
            a = 32'h100 + ($urandom % 32'hF8); wd = $urandom;
            ref_model(we, f3, a, wd, er, ee, ea, el);
            xact(we, f3, a, wd, rd, e, nacc, nwe, lat, fa, famp, fwd);
            n_cmp++;
            if (rd !== er) begin
                n_fail++;
                $display("FAIL rnd_rdata[%0d] we=%b f3=%b a=%h: got %h required %h", t, we, f3, a, rd, er);
            end
            n_cmp++;
            if (e !== ee) begin
                n_fail++;
                $display("FAIL rnd_err[%0d] we=%b f3=%b a=%h: got %b required %b", t, we, f3, a, e, ee);
            end
            n_cmp++;
            if (nacc !== ea) begin
                n_fail++;
                $display("FAIL rnd_acc[%0d] we=%b f3=%b a=%h: got %0d required %0d", t, we, f3, a, nacc, ea);
            end
            n_cmp++;
            if (nwe !== ((we && !ee) ? ea : 0)) begin
                n_fail++;
                $display("FAIL rnd_we[%0d] we=%b f3=%b a=%h: got %0d required %0d",
                         t, we, f3, a, nwe, (we && !ee) ? ea : 0);
            end
            n_cmp++;
            if (lat !== el) begin
                n_fail++;
                $display("FAIL rnd_lat[%0d] we=%b f3=%b a=%h: got %0d required %0d", t, we, f3, a, lat, el);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] base;
        base = SPLIT ? 32'h81 : 32'h80;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = base; req_wdata = 32'hAABB_CCDD;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        if (SPLIT) begin
            @(negedge clk);
            ref_mem[10'(base)] = 8'hDD;
        end
        n_cmp++;
        if (dm_a !== base + 32'(SPLIT) || dm_we !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_acc: a=%h we=%b required %h/1", dm_a, dm_we, base + 32'(SPLIT));
        end
        rstn = 1'b0;
        #1;
        n_cmp++;
        if ({req_ready, resp_valid, dm_we, dm_amp} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL rst_mid_idle: rdy/rv/we/amp=%b required 1000000",
                     {req_ready, resp_valid, dm_we, dm_amp});
        end
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (mem[10'(base + 32'(i))] !== ref_mem[10'(base + 32'(i))]) begin
                n_fail++;
                $display("FAIL rst_mid_mem[%0d]: byte=%h required %h",
                         i, mem[10'(base + 32'(i))], ref_mem[10'(base + 32'(i))]);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
        test_reset();
        test_store_byte();
        test_load_ext();
        test_backpressure();
        test_misaligned();
        test_illegal();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
